store_buffer: RTL and testbench
===============================

// Module: store_buffer
// PURPOSE
//   Parametrised store path between execute/memory stage and data-memory port. Formats
//   SB/SH/SW(/SD) data and byte mask for an XLEN-wide bus and detects misaligned stores.
//   Queues committed stores in a DEPTH-entry in-order FIFO and drains them via valid/ready.
//   Flags loads that hit a pending store word so the load path can stall.
// PARAMETERS
//   XLEN   32  data-bus width, 32 or 64; byte lanes NB = XLEN/8, offset bits OFFW = log2(NB)
//   DEPTH  4   FIFO entries; power of 2, >= 2
//   AW     32  byte-address width
// PORTS
//   CLK             in   1       clock
//   RST             in   1       synchronous active-high reset
//   REQ_VALID       in   1       store request valid
//   REQ_READY       out  1       buffer can accept (count < DEPTH)
//   REQ_OP          in   mem_op_t  memory op; only MEM_SB/SH/SW/SD are stores
//   REQ_ADDR        in   AW      byte address
//   REQ_WDATA       in   XLEN    unformatted store data, LSB-justified
//   TRAP_VALID      out  1       misaligned-store trap, 1-cycle pulse
//   TRAP_MCAUSE     out  31      TRAP_CODE_STORE_ADDR_MISALIGNED while TRAP_VALID, else 0
//   MEM_VALID       out  1       head entry valid (FIFO not empty)
//   MEM_READY       in   1       memory accepts head
//   MEM_ADDR        out  AW      head address, low OFFW bits zero
//   MEM_WMASK       out  NB      head byte-write mask
//   MEM_WDATA       out  XLEN    head lane-aligned data
//   LD_CHECK_ADDR   in   AW      address of load under issue
//   LD_HAZARD       out  1       combinational: some valid entry has same word address
//   EMPTY           out  1       no entries pending (fence/drain check)
// BEHAVIOUR
//   - Reset: count, head/tail pointers = 0; MEM_VALID=0, EMPTY=1, TRAP_VALID=0, TRAP_MCAUSE=0.
//     Reset mid-operation discards all queued stores; memory sees MEM_VALID=0 next cycle.
//   - Handshake: push = REQ_VALID & REQ_READY & is_store; pop = MEM_VALID & MEM_READY.
//     REQ_READY = (count < DEPTH), no same-cycle pass-through when full. Push+pop same
//     cycle: count unchanged, both pointers advance (mod DEPTH).
//   - Non-store REQ_OP (incl. MEM_SD when XLEN=32): no enqueue, no trap.
//   - Alignment: SB any; SH addr[0]=0; SW addr[1:0]=0; SD addr[2:0]=0. Misaligned store at
//     handshake: no enqueue; TRAP_VALID=1 and TRAP_MCAUSE set in the following cycle only.
//   - Formatting, off = REQ_ADDR[OFFW-1:0]: base mask SB=1, SH=3, SW=0xF, SD=0xFF;
//     wmask = base << off; wdata = REQ_WDATA << 8*off, truncated to XLEN.
//     Stored address = REQ_ADDR with low OFFW bits cleared.
//   - Latency: accepted store appears at MEM_* in the cycle after push. MEM_* stay stable
//     while MEM_VALID & !MEM_READY. Strict in-order drain.
//   - LD_HAZARD: word(LD_CHECK_ADDR) == word(entry.addr) for any valid entry; a pushing
//     store is not visible until the next cycle; an entry popping this cycle still counts.
//   - EMPTY = (count == 0); MEM_VALID = !EMPTY.
// STRUCTURE
//   - params_pkg: add MEM_SD to mem_op_t; store_entry_t {addr, wmask, wdata} parametrised
//     by the localparams above; reuse TRAP_CODE_STORE_ADDR_MISALIGNED.
//   - Sub-module store_format: combinational op/addr/data -> {is_store, misaligned,
//     wmask, wdata}. Top holds the FIFO array, pointers, count, trap register and
//     hazard compare.
// TESTING
//   1. XLEN=32, MEM_READY=1: SW 0x100 / 0xDEADBEEF -> next cycle MEM_VALID, MEM_ADDR 0x100,
//      WMASK 0xF, WDATA 0xDEADBEEF; following cycle EMPTY=1.
//   2. SB 0x103 / 0xAB -> WMASK 0x8, WDATA 0xAB000000; SH 0x102 / 0x1234 -> WMASK 0xC,
//      WDATA 0x12340000, MEM_ADDR 0x100 for both.
//   3. SH 0x101, then SW 0x102 -> nothing enqueued; TRAP_VALID pulses 1 cycle each,
//      TRAP_MCAUSE = 6; EMPTY stays 1.
//   4. MEM_READY=0, push 5 SW -> REQ_READY=0 after 4th; 5th held; then MEM_READY=1 ->
//      all 5 drain in push order with no loss or duplication.
//   5. Pending SW 0x200: LD_CHECK_ADDR 0x202 -> LD_HAZARD=1; 0x204 -> 0; after drain -> 0.
//   6. XLEN=64: SD 0x108 -> WMASK 0xFF, MEM_ADDR 0x108; queue 3 entries, pulse RST ->
//      next cycle MEM_VALID=0, EMPTY=1, TRAP_VALID=0.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: memory op encoding, trap code and store byte-mask helper
package store_buffer_pkg;
  typedef enum logic [3:0] {
    MEM_NONE, MEM_LB, MEM_LH, MEM_LW, MEM_LD, MEM_LBU, MEM_LHU, MEM_LWU,
    MEM_SB, MEM_SH, MEM_SW, MEM_SD
  } mem_op_t;
  localparam logic [30:0] TRAP_CODE_STORE_ADDR_MISALIGNED = 31'd6;
  function automatic logic [7:0] base_mask(mem_op_t op);
    return op == MEM_SB ? 8'h01 : op == MEM_SH ? 8'h03 : op == MEM_SW ? 8'h0F : 8'hFF;
  endfunction
endpackage

// File: rtl/store_format.sv
// store_format: classifies a store op, checks alignment and lane-aligns mask/data
module store_format
  import store_buffer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  mem_op_t           op,
  input  logic [2:0]        lo,
  input  logic [XLEN-1:0]   data,
  output logic              is_store,
  output logic              misaligned,
  output logic [XLEN/8-1:0] wmask,
  output logic [XLEN-1:0]   wdata
);
  localparam int NB = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  logic [OFFW-1:0] off;
  // SD only counts as a store on a 64-bit bus; lanes shift by the byte offset
  always_comb begin
    off = lo[OFFW-1:0];
    is_store = op inside {MEM_SB, MEM_SH, MEM_SW} || (op == MEM_SD && XLEN == 64);
    misaligned = (op == MEM_SH && lo[0]) || (op == MEM_SW && lo[1:0] != 2'b00) ||
                 (op == MEM_SD && lo != 3'b000);
    wmask = NB'(base_mask(op)) << off;
    wdata = data << {off, 3'b000};
  end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: formats stores, queues them in order and drains them to memory
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  mem_op_t           req_op,
  input  logic [AW-1:0]     req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              trap_valid,
  output logic [30:0]       trap_mcause,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [AW-1:0]     mem_addr,
  output logic [XLEN/8-1:0] mem_wmask,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [AW-1:0]     ld_check_addr,
  output logic              ld_hazard,
  output logic              empty
);
  localparam int NB = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int PW = $clog2(DEPTH);
  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [NB-1:0]   wmask;
    logic [XLEN-1:0] wdata;
  } store_entry_t;
  store_entry_t q [DEPTH];
  logic [PW-1:0] head, tail;
  logic [PW:0] count;
  logic is_store, misaligned, hs, push, pop;
  logic [NB-1:0] f_mask;
  logic [XLEN-1:0] f_data;
  store_format #(.XLEN(XLEN)) u_fmt (
    .op(req_op), .lo(req_addr[2:0]), .data(req_wdata),
    .is_store(is_store), .misaligned(misaligned), .wmask(f_mask), .wdata(f_data)
  );
  assign req_ready = count < (PW+1)'(DEPTH);
  assign hs = req_valid & req_ready & is_store;
  assign push = hs & ~misaligned;
  assign pop = mem_valid & mem_ready;
  assign empty = count == '0;
  assign mem_valid = ~empty;
  assign mem_addr = q[head].addr;
  assign mem_wmask = q[head].wmask;
  assign mem_wdata = q[head].wdata;
  assign trap_mcause = trap_valid ? TRAP_CODE_STORE_ADDR_MISALIGNED : '0;
  // Entry storage; validity comes from count, so contents need no reset
  always_ff @(posedge clk)
    if (push) q[tail] <= '{addr: {req_addr[AW-1:OFFW], OFFW'(0)}, wmask: f_mask, wdata: f_data};
  // Pointers, occupancy and the one-cycle misaligned-store trap pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      trap_valid <= 1'b0;
    end else begin
      head <= pop ? head + PW'(1) : head;
      tail <= push ? tail + PW'(1) : tail;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      trap_valid <= hs & misaligned;
    end
  end
  // Word-granular match of the load address against every occupied slot
  always_comb begin
    ld_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      ld_hazard = ld_hazard | (({1'b0, PW'(i) - head} < count) &&
                  (((q[i].addr ^ ld_check_addr) >> OFFW) == '0));
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: vector table plus scoreboard for 32- and 64-bit store buffers
module tb_store_buffer;
  import store_buffer_pkg::*;
  typedef struct {
    logic [31:0] a;
    logic [7:0]  m;
    logic [63:0] d;
  } exp_t;
  typedef struct {
    mem_op_t     op;
    logic [31:0] addr;
    logic [31:0] data;
    logic        trap;
    logic        enq;
    logic [31:0] ea;
    logic [3:0]  em;
    logic [31:0] ed;
  } vec_t;
  logic clk = 1'b0;
  logic rst32, rst64, v32, v64, mem_ready;
  mem_op_t op;
  logic [31:0] addr, ld_addr;
  logic [63:0] wdata;
  logic rdy32, trap32, mv32, hz32, e32;
  logic [30:0] mc32;
  logic [31:0] ma32, md32;
  logic [3:0] mm32;
  logic rdy64, trap64, mv64, hz64, e64;
  logic [30:0] mc64;
  logic [31:0] ma64;
  logic [63:0] md64;
  logic [7:0] mm64;
  exp_t q32[$], q64[$];
  vec_t vt[11];
  int n_cmp = 0, n_fail = 0;
  always #5 clk = ~clk;
  store_buffer #(.XLEN(32), .DEPTH(4), .AW(32)) dut32 (
    .clk(clk), .rst(rst32), .req_valid(v32), .req_ready(rdy32), .req_op(op),
    .req_addr(addr), .req_wdata(wdata[31:0]), .trap_valid(trap32), .trap_mcause(mc32),
    .mem_valid(mv32), .mem_ready(mem_ready), .mem_addr(ma32), .mem_wmask(mm32),
    .mem_wdata(md32), .ld_check_addr(ld_addr), .ld_hazard(hz32), .empty(e32)
  );
  store_buffer #(.XLEN(64), .DEPTH(4), .AW(32)) dut64 (
    .clk(clk), .rst(rst64), .req_valid(v64), .req_ready(rdy64), .req_op(op),
    .req_addr(addr), .req_wdata(wdata), .trap_valid(trap64), .trap_mcause(mc64),
    .mem_valid(mv64), .mem_ready(mem_ready), .mem_addr(ma64), .mem_wmask(mm64),
    .mem_wdata(md64), .ld_check_addr(ld_addr), .ld_hazard(hz64), .empty(e64)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, wanted %h", name, act, exp);
    end
  endtask
  task automatic tick();
    logic a32, a64;
    exp_t e;
    @(negedge clk);
    if (mv32 && mem_ready) begin
      if (q32.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL drain32 unexpected: got addr %h, wanted no entry", ma32);
      end else begin
        e = q32.pop_front();
        chk("drain32 addr", 64'(ma32), 64'(e.a));
        chk("drain32 mask", 64'(mm32), 64'(e.m));
        chk("drain32 data", 64'(md32), e.d);
      end
    end
    if (mv64 && mem_ready) begin
      if (q64.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL drain64 unexpected: got addr %h, wanted no entry", ma64);
      end else begin
        e = q64.pop_front();
        chk("drain64 addr", 64'(ma64), 64'(e.a));
        chk("drain64 mask", 64'(mm64), 64'(e.m));
        chk("drain64 data", md64, e.d);
      end
    end
    a32 = v32 & rdy32;
    a64 = v64 & rdy64;
    @(posedge clk);
    #1;
    if (a32) v32 = 1'b0;
    if (a64) v64 = 1'b0;
  endtask
  initial begin
    vt[0]  = '{MEM_SW, 32'h100, 32'hDEADBEEF, 1'b0, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF};
    vt[1]  = '{MEM_SB, 32'h103, 32'h000000AB, 1'b0, 1'b1, 32'h100, 4'h8, 32'hAB000000};
    vt[2]  = '{MEM_SH, 32'h102, 32'h00001234, 1'b0, 1'b1, 32'h100, 4'hC, 32'h12340000};
    vt[3]  = '{MEM_SB, 32'h101, 32'h000000CD, 1'b0, 1'b1, 32'h100, 4'h2, 32'h0000CD00};
    vt[4]  = '{MEM_SH, 32'h100, 32'h00005678, 1'b0, 1'b1, 32'h100, 4'h3, 32'h00005678};
    vt[5]  = '{MEM_SB, 32'h102, 32'h12345678, 1'b0, 1'b1, 32'h100, 4'h4, 32'h56780000};
    vt[6]  = '{MEM_SB, 32'h3FF, 32'h000001FF, 1'b0, 1'b1, 32'h3FC, 4'h8, 32'hFF000000};
    vt[7]  = '{MEM_SH, 32'h101, 32'h00001111, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0};
    vt[8]  = '{MEM_SW, 32'h102, 32'h22222222, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0};
    vt[9]  = '{MEM_SD, 32'h10C, 32'h33333333, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0};
    vt[10] = '{MEM_LW, 32'h101, 32'h44444444, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0};
    rst32 = 1'b1;
    rst64 = 1'b1;
    v32 = 1'b0;
    v64 = 1'b0;
    mem_ready = 1'b0;
    op = MEM_NONE;
    addr = '0;
    wdata = '0;
    ld_addr = 32'hFFF0;
    tick();
    tick();
    rst32 = 1'b0;
    rst64 = 1'b0;
    chk("reset empty32", 64'(e32), 64'd1);
    chk("reset mvalid32", 64'(mv32), 64'd0);
    chk("reset trap32", 64'(trap32), 64'd0);
    chk("reset mcause32", 64'(mc32), 64'd0);
    chk("reset ready32", 64'(rdy32), 64'd1);
    chk("reset empty64", 64'(e64), 64'd1);
    chk("reset mvalid64", 64'(mv64), 64'd0);
    mem_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      op = vt[i].op;
      addr = vt[i].addr;
      wdata = {32'h0, vt[i].data};
      v32 = 1'b1;
      if (vt[i].enq) q32.push_back('{vt[i].ea, {4'h0, vt[i].em}, {32'h0, vt[i].ed}});
      tick();
      chk($sformatf("vec%0d trap", i), 64'(trap32), 64'(vt[i].trap));
      chk($sformatf("vec%0d mcause", i), 64'(mc32), vt[i].trap ? 64'd6 : 64'd0);
      chk($sformatf("vec%0d mvalid", i), 64'(mv32), 64'(vt[i].enq));
      tick();
      chk($sformatf("vec%0d empty after", i), 64'(e32), 64'd1);
      chk($sformatf("vec%0d trap cleared", i), 64'(trap32), 64'd0);
    end
    chk("vectors drained", 64'(q32.size()), 64'd0);
    mem_ready = 1'b0;
    op = MEM_SW;
    for (int i = 0; i < 4; i++) begin
      addr = 32'h300 + 32'(4 * i);
      wdata = 64'(32'hA0 + i);
      v32 = 1'b1;
      chk($sformatf("fill%0d ready", i), 64'(rdy32), 64'd1);
      q32.push_back('{addr, 8'h0F, wdata});
      tick();
    end
    chk("full ready", 64'(rdy32), 64'd0);
    addr = 32'h310;
    wdata = 64'hA4;
    v32 = 1'b1;
    q32.push_back('{32'h310, 8'h0F, 64'hA4});
    tick();
    tick();
    chk("full held ready", 64'(rdy32), 64'd0);
    chk("stall addr", 64'(ma32), 64'h300);
    chk("stall data", 64'(md32), 64'hA0);
    mem_ready = 1'b1;
    for (int k = 0; k < 20 && q32.size() != 0; k++) tick();
    chk("fifo drain remaining", 64'(q32.size()), 64'd0);
    tick();
    chk("fifo drain empty", 64'(e32), 64'd1);
    mem_ready = 1'b0;
    addr = 32'h200;
    wdata = 64'h55;
    ld_addr = 32'h202;
    v32 = 1'b1;
    q32.push_back('{32'h200, 8'h0F, 64'h55});
    #1;
    chk("hazard pushing", 64'(hz32), 64'd0);
    tick();
    chk("hazard same word", 64'(hz32), 64'd1);
    ld_addr = 32'h204;
    #1;
    chk("hazard next word", 64'(hz32), 64'd0);
    ld_addr = 32'h1FC;
    #1;
    chk("hazard prev word", 64'(hz32), 64'd0);
    ld_addr = 32'h203;
    mem_ready = 1'b1;
    #1;
    chk("hazard popping", 64'(hz32), 64'd1);
    tick();
    chk("hazard drained", 64'(hz32), 64'd0);
    chk("hazard drained empty", 64'(e32), 64'd1);
    op = MEM_SD;
    addr = 32'h108;
    wdata = 64'h1122334455667788;
    v64 = 1'b1;
    q64.push_back('{32'h108, 8'hFF, 64'h1122334455667788});
    tick();
    chk("sd trap", 64'(trap64), 64'd0);
    chk("sd mvalid", 64'(mv64), 64'd1);
    ld_addr = 32'h10C;
    #1;
    chk("hazard64 dword", 64'(hz64), 64'd1);
    tick();
    chk("sd empty after", 64'(e64), 64'd1);
    op = MEM_SW;
    addr = 32'h10C;
    wdata = 64'hAABBCCDD;
    v64 = 1'b1;
    q64.push_back('{32'h108, 8'hF0, 64'hAABBCCDD00000000});
    tick();
    tick();
    op = MEM_SB;
    addr = 32'h10F;
    wdata = 64'h7E;
    v64 = 1'b1;
    q64.push_back('{32'h108, 8'h80, 64'h7E00000000000000});
    tick();
    tick();
    chk("sw/sb64 empty after", 64'(e64), 64'd1);
    op = MEM_SD;
    addr = 32'h10C;
    v64 = 1'b1;
    tick();
    chk("sd misaligned trap", 64'(trap64), 64'd1);
    chk("sd misaligned mcause", 64'(mc64), 64'd6);
    chk("sd misaligned empty", 64'(e64), 64'd1);
    tick();
    chk("sd trap pulse", 64'(trap64), 64'd0);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      addr = 32'h400 + 32'(8 * i);
      wdata = 64'(i);
      v64 = 1'b1;
      tick();
    end
    chk("queued before reset", 64'(mv64), 64'd1);
    addr = 32'h401;
    v64 = 1'b1;
    rst64 = 1'b1;
    tick();
    rst64 = 1'b0;
    v64 = 1'b0;
    chk("midreset mvalid", 64'(mv64), 64'd0);
    chk("midreset empty", 64'(e64), 64'd1);
    chk("midreset trap", 64'(trap64), 64'd0);
    chk("midreset mcause", 64'(mc64), 64'd0);
    chk("midreset ready", 64'(rdy64), 64'd1);
    mem_ready = 1'b1;
    addr = 32'h500;
    wdata = 64'hCAFEF00D12345678;
    v64 = 1'b1;
    q64.push_back('{32'h500, 8'hFF, 64'hCAFEF00D12345678});
    tick();
    tick();
    chk("post reset drained", 64'(q64.size()), 64'd0);
    chk("post reset empty", 64'(e64), 64'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
